// File: rtl/queue_reader.sv
// Consumer-side controller for the 8x32 queue: pops words, captures the registered data_out and streams them on valid/ready.
// Optional statistics outputs (words_read, pop_collisions) are built when QUEUE_READER_STATS_EN is defined.
module queue_reader #(
    parameter int word_length  = 8,
    parameter int buffer_depth = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stack_empty,
    input  logic                   stack_full,
    input  logic                   write_to_stack,
    input  logic [word_length-1:0] stack_data,
    output logic                   read_from_stack,
    output logic [word_length-1:0] out_data,
    output logic                   out_valid,
    input  logic                   out_ready
`ifdef QUEUE_READER_STATS_EN
    ,
    output logic [15:0]            words_read,
    output logic [7:0]             pop_collisions
`endif
);

    // Stream handshake: a word moves when out_valid && out_ready at a rising edge;
    // out_data/out_valid never change while out_valid is high and out_ready is low.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } count_t;

    localparam logic [2:0] depth = 3'(buffer_depth);

    count_t                 count;
    logic                   inflight;
    logic [word_length-1:0] head;
    logic [word_length-1:0] tail;
    logic                   deq;
    logic                   capture;
    logic                   pop_ok;
    logic [2:0]             level;
    logic [2:0]             count_next;

    assign deq        = out_valid && out_ready;
    assign capture    = inflight;
    assign level      = {1'b0, count} + {2'b00, inflight} - {2'b00, deq};
    assign count_next = {1'b0, count} + {2'b00, capture} - {2'b00, deq};

    // Only pop when the word can be guaranteed a buffer slot on arrival.
    assign read_from_stack = reset && !stack_empty && (level < depth);

    // The queue serves an accepted write instead of a pop in the same cycle.
    assign pop_ok   = read_from_stack && !(write_to_stack && !stack_full);
    assign out_data = head;

    always_ff @(posedge clk) begin
        if (!reset) begin
            count     <= EMPTY;
            inflight  <= 1'b0;
            head      <= '0;
            tail      <= '0;
            out_valid <= 1'b0;
        end else begin
            inflight  <= pop_ok;
            out_valid <= (count_next != 3'd0);
            case (count_next)
                3'd0:    count <= EMPTY;
                3'd1:    count <= ONE;
                default: count <= TWO;
            endcase
            if (deq && count == TWO) begin
                head <= tail;
                if (capture) begin
                    tail <= stack_data;
                end
            end else if (capture) begin
                // deq here implies a single entry leaving, so the new word becomes the head.
                if (count == EMPTY || deq) begin
                    head <= stack_data;
                end else begin
                    tail <= stack_data;
                end
            end
        end
    end

    assert property (@(posedge clk) disable iff (!reset) count_next <= depth);

`ifdef QUEUE_READER_STATS_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            words_read     <= 16'd0;
            pop_collisions <= 8'd0;
        end else begin
            if (deq) begin
                words_read <= words_read + 16'd1;
            end
            if (read_from_stack && !pop_ok && pop_collisions != 8'hFF) begin
                pop_collisions <= pop_collisions + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_queue_reader.sv
// Directed bench for queue_reader with a small behavioural model of the 8x32 write-priority queue.
module tb_queue_reader;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         stack_empty;
    logic         stack_full;
    logic         write_to_stack;
    logic [W-1:0] stack_data;
    logic         read_from_stack;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready;
`ifdef QUEUE_READER_STATS_EN
    logic [15:0]  words_read;
    logic [7:0]   pop_collisions;
`endif

    logic [W-1:0] wdata;
    logic         q_flush;
    logic         q_bypass;
    logic [W-1:0] mem [32];
    logic [4:0]   rp;
    logic [4:0]   wp;
    logic [5:0]   cnt;
    logic         wr_ok;
    logic         rd_ok;

    int vectors = 0;
    int errors  = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] rx_q[$];

    always #5 clk = ~clk;

    queue_reader #(.word_length(W), .buffer_depth(2)) dut (
        .clk            (clk),
        .reset          (reset),
        .stack_empty    (stack_empty),
        .stack_full     (stack_full),
        .write_to_stack (write_to_stack),
        .stack_data     (stack_data),
        .read_from_stack(read_from_stack),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready)
`ifdef QUEUE_READER_STATS_EN
        ,
        .words_read     (words_read),
        .pop_collisions (pop_collisions)
`endif
    );

    // Queue model: registered data_out, writes win over a same-cycle pop.
    assign stack_empty = q_bypass ? 1'b0 : (cnt == 6'd0);
    assign stack_full  = (cnt == 6'd32);

    always @(posedge clk) begin
        wr_ok = write_to_stack && !stack_full;
        rd_ok = read_from_stack && !stack_empty && !wr_ok;
        if (q_flush) begin
            cnt        <= 6'd0;
            rp         <= 5'd0;
            wp         <= 5'd0;
            stack_data <= '0;
        end else begin
            if (wr_ok) begin
                mem[wp] <= wdata;
                wp      <= wp + 5'd1;
            end
            if (rd_ok) begin
                if (q_bypass) begin
                    stack_data <= stack_data + 8'd1;
                end else begin
                    stack_data <= mem[rp];
                    rp         <= rp + 5'd1;
                end
            end
            cnt <= cnt + {5'd0, wr_ok} - {5'd0, rd_ok && !q_bypass};
        end
    end

    // Driver: flush the queue and fill it with n words while the reader is held in reset.
    task automatic preload(input logic [W-1:0] first, input logic [W-1:0] step, input int n);
        reset   = 1'b0;
        q_flush = 1'b1;
        @(negedge clk);
        q_flush = 1'b0;
        for (int i = 0; i < n; i++) begin
            write_to_stack = 1'b1;
            wdata          = first + W'(i) * step;
            @(negedge clk);
        end
        write_to_stack = 1'b0;
    endtask

    // Driver: record every word that will be accepted at the next rising edge.
    task automatic collect(input int cycles);
        rx_q.delete();
        for (int i = 0; i < cycles; i++) begin
            if (out_valid && out_ready) rx_q.push_back(out_data);
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; write_to_stack = 1'b0; wdata = '0; out_ready = 1'b0;
        q_flush = 1'b1; q_bypass = 1'b0;
        repeat (2) @(negedge clk);
        q_flush = 1'b0;
        #1;
        vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        vectors++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", out_data); end
        vectors++; if (read_from_stack !== 1'b0) begin errors++; $display("FAIL reset_read: got %b expected 0", read_from_stack); end
    endtask

    task automatic test_stream();
        logic         ev [5];
        logic [W-1:0] ed [5];
        logic         er [5];
        ev = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        ed = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h00};
        er = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        preload(8'h11, 8'h11, 3);
        out_ready = 1'b1;
        #1;
        vectors++; if (read_from_stack !== 1'b0) begin errors++; $display("FAIL stream_read_in_reset: got %b expected 0", read_from_stack); end
        reset = 1'b1;
        #1;
        vectors++; if (read_from_stack !== 1'b1) begin errors++; $display("FAIL stream_first_pop: got %b expected 1", read_from_stack); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vectors++; if (out_valid !== ev[i]) begin errors++; $display("FAIL stream_valid[%0d]: got %b expected %b", i, out_valid, ev[i]); end
            if (ev[i]) begin
                vectors++; if (out_data !== ed[i]) begin errors++; $display("FAIL stream_data[%0d]: got %h expected %h", i, out_data, ed[i]); end
            end
            vectors++; if (read_from_stack !== er[i]) begin errors++; $display("FAIL stream_read[%0d]: got %b expected %b", i, read_from_stack, er[i]); end
        end
    endtask

    task automatic test_backpressure();
        int pops;
        logic [W-1:0] e;
        logic [W-1:0] a;
        preload(8'h41, 8'h01, 4);
        out_ready = 1'b0;
        reset     = 1'b1;
        pops      = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (read_from_stack) pops++;
            @(negedge clk);
        end
        vectors++; if (pops !== 2) begin errors++; $display("FAIL bp_pops: got %0d expected 2", pops); end
        vectors++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid: got %b expected 1", out_valid); end
        vectors++; if (out_data !== 8'h41) begin errors++; $display("FAIL bp_hold: got %h expected 41", out_data); end
        out_ready = 1'b1;
        #1;
        vectors++; if (read_from_stack !== 1'b1) begin errors++; $display("FAIL bp_reissue: got %b expected 1", read_from_stack); end
        collect(8);
        exp_q = '{8'h41, 8'h42, 8'h43, 8'h44};
        vectors++; if (rx_q.size() !== exp_q.size()) begin errors++; $display("FAIL bp_count: got %0d expected %0d", rx_q.size(), exp_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
            vectors++; if (a !== e) begin errors++; $display("FAIL bp_order: got %h expected %h", a, e); end
        end
    endtask

    task automatic test_collision();
        logic [W-1:0] e;
        logic [W-1:0] a;
        preload(8'h51, 8'h00, 1);
        out_ready      = 1'b1;
        reset          = 1'b1;
        write_to_stack = 1'b1;
        wdata          = 8'h52;
        #1;
        vectors++; if (read_from_stack !== 1'b1) begin errors++; $display("FAIL coll_pop: got %b expected 1", read_from_stack); end
        @(negedge clk);
        write_to_stack = 1'b0;
        #1;
        vectors++; if (read_from_stack !== 1'b1) begin errors++; $display("FAIL coll_reissue: got %b expected 1", read_from_stack); end
        @(negedge clk);
        vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL coll_no_capture: got %b expected 0", out_valid); end
        collect(6);
        exp_q = '{8'h51, 8'h52};
        vectors++; if (rx_q.size() !== exp_q.size()) begin errors++; $display("FAIL coll_count: got %0d expected %0d", rx_q.size(), exp_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
            vectors++; if (a !== e) begin errors++; $display("FAIL coll_order: got %h expected %h", a, e); end
        end
`ifdef QUEUE_READER_STATS_EN
        vectors++; if (pop_collisions !== 8'd1) begin errors++; $display("FAIL coll_stat: got %0d expected 1", pop_collisions); end
`endif
    endtask

    task automatic test_single_write();
        write_to_stack = 1'b1;
        wdata          = 8'hA5;
        #1;
        vectors++; if (read_from_stack !== 1'b0) begin errors++; $display("FAIL sw_idle_read: got %b expected 0", read_from_stack); end
        @(negedge clk);
        write_to_stack = 1'b0;
        #1;
        vectors++; if (read_from_stack !== 1'b1) begin errors++; $display("FAIL sw_pop: got %b expected 1", read_from_stack); end
        @(negedge clk);
        vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL sw_wait: got %b expected 0", out_valid); end
        vectors++; if (read_from_stack !== 1'b0) begin errors++; $display("FAIL sw_read_empty: got %b expected 0", read_from_stack); end
        @(negedge clk);
        vectors++; if (out_valid !== 1'b1) begin errors++; $display("FAIL sw_valid: got %b expected 1", out_valid); end
        vectors++; if (out_data !== 8'hA5) begin errors++; $display("FAIL sw_data: got %h expected a5", out_data); end
        @(negedge clk);
        vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL sw_drained: got %b expected 0", out_valid); end
    endtask

    task automatic test_reset_mid();
        preload(8'h61, 8'h01, 4);
        out_ready = 1'b0;
        reset     = 1'b1;
        repeat (2) @(negedge clk);
        vectors++; if (out_data !== 8'h61) begin errors++; $display("FAIL rm_head: got %h expected 61", out_data); end
        reset   = 1'b0;
        q_flush = 1'b1;
        #1;
        vectors++; if (read_from_stack !== 1'b0) begin errors++; $display("FAIL rm_read_forced: got %b expected 0", read_from_stack); end
        @(negedge clk);
        vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rm_valid: got %b expected 0", out_valid); end
        vectors++; if (out_data !== 8'h00) begin errors++; $display("FAIL rm_data: got %h expected 00", out_data); end
        reset   = 1'b1;
        q_flush = 1'b0;
        out_ready = 1'b1;
        #1;
        vectors++; if (read_from_stack !== 1'b0) begin errors++; $display("FAIL rm_read_after: got %b expected 0", read_from_stack); end
        collect(4);
        vectors++; if (rx_q.size() !== 0) begin errors++; $display("FAIL rm_stale: got %0d words expected 0", rx_q.size()); end
    endtask

`ifdef QUEUE_READER_STATS_EN
    task automatic test_stats_wrap();
        int n;
        int guard;
        reset   = 1'b0;
        q_flush = 1'b1;
        @(negedge clk);
        q_flush   = 1'b0;
        q_bypass  = 1'b1;
        reset     = 1'b1;
        out_ready = 1'b1;
        n = 0;
        guard = 0;
        while (n < 65537 && guard < 70000) begin
            if (out_valid) n++;
            @(negedge clk);
            guard++;
        end
        out_ready = 1'b0;
        q_bypass  = 1'b0;
        vectors++; if (n !== 65537) begin errors++; $display("FAIL stats_timeout: got %0d words expected 65537", n); end
        vectors++; if (words_read !== 16'h0001) begin errors++; $display("FAIL stats_wrap: got %h expected 0001", words_read); end
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_collision();
        test_single_write();
        test_reset_mid();
`ifdef QUEUE_READER_STATS_EN
        test_stats_wrap();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
